// File: rtl/gemm_c_drain.sv
// Result-drain engine: reads packed C tile words from SRAM and streams single
// elements with (row, col) coordinates under a valid/ready handshake.
module gemm_c_drain #(
  parameter int unsigned OutDataWidth  = 32,
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    start_i,
  input  logic [SizeAddrWidth-1:0]                M_size_i,
  input  logic [SizeAddrWidth-1:0]                N_size_i,
  output logic [AddrWidth-1:0]                    sram_c_addr_o,
  output logic                                    sram_c_re_o,
  input  logic [RowPar*ColPar*OutDataWidth-1:0]   sram_c_rdata_i,
  output logic [OutDataWidth-1:0]                 out_data_o,
  output logic [SizeAddrWidth-1:0]                out_row_o,
  output logic [SizeAddrWidth-1:0]                out_col_o,
  output logic                                    out_last_o,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic                                    busy_o,
  output logic                                    done_o
);

  localparam int unsigned Elems     = RowPar * ColPar;
  localparam int unsigned TileWidth = Elems * OutDataWidth;
  localparam int unsigned MW        = (RowPar > 1) ? $clog2(RowPar) : 1;
  localparam int unsigned NW        = (ColPar > 1) ? $clog2(ColPar) : 1;

  localparam logic [MW-1:0]            MLast   = MW'(RowPar - 1);
  localparam logic [NW-1:0]            NLast   = NW'(ColPar - 1);
  localparam logic [MW-1:0]            MOne    = MW'(1);
  localparam logic [NW-1:0]            NOne    = NW'(1);
  localparam logic [MW-1:0]            MZero   = MW'(0);
  localparam logic [NW-1:0]            NZero   = NW'(0);
  localparam logic [SizeAddrWidth-1:0] RowParS = SizeAddrWidth'(RowPar);
  localparam logic [SizeAddrWidth-1:0] ColParS = SizeAddrWidth'(ColPar);
  localparam logic [SizeAddrWidth-1:0] SZero   = SizeAddrWidth'(0);
  localparam logic [AddrWidth-1:0]     AddrOne = AddrWidth'(1);
  localparam logic [AddrWidth-1:0]     AZero   = AddrWidth'(0);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StWait  = 3'd2,
    StEmit  = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Element (0,0) sits in the MSBs of the tile word.
  function automatic logic [OutDataWidth-1:0] tile_elem(
    input logic [TileWidth-1:0] tile,
    input logic [MW-1:0]        m,
    input logic [NW-1:0]        n
  );
    logic [31:0] idx;
    idx = 32'(m) * ColPar + 32'(n);
    return tile[(Elems - 1 - idx) * OutDataWidth +: OutDataWidth];
  endfunction

  state_e                 state_r, state_s;
  logic [SizeAddrWidth-1:0] m_tiles_r, m_tiles_s, n_tiles_r, n_tiles_s;
  logic [SizeAddrWidth-1:0] row_base_r, row_base_s, col_base_r, col_base_s;
  logic [AddrWidth-1:0]   mt_r, mt_s, nt_r, nt_s, tile_addr_r, tile_addr_s;
  logic [MW-1:0]          m_r, m_s;
  logic [NW-1:0]          n_r, n_s;
  logic [TileWidth-1:0]   buf_r, buf_s;

  logic [AddrWidth-1:0]     addr_r, addr_s;
  logic                     re_r, re_s;
  logic [OutDataWidth-1:0]  data_r, data_s;
  logic [SizeAddrWidth-1:0] row_r, row_s, col_r, col_s;
  logic                     last_r, last_s;
  logic                     valid_r, valid_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;

  logic hs_s, elem_last_s, nt_last_s, tile_final_s, final_next_s;

  assign hs_s         = valid_r & out_ready_i;
  assign elem_last_s  = (m_r == MLast) && (n_r == NLast);
  assign nt_last_s    = (nt_r == AddrWidth'(n_tiles_r) - AddrOne);
  assign tile_final_s = (mt_r == AddrWidth'(m_tiles_r) - AddrOne) && nt_last_s;

  // Next-state and counter update logic.
  always_comb begin
    state_s     = state_r;
    m_tiles_s   = m_tiles_r;
    n_tiles_s   = n_tiles_r;
    row_base_s  = row_base_r;
    col_base_s  = col_base_r;
    mt_s        = mt_r;
    nt_s        = nt_r;
    tile_addr_s = tile_addr_r;
    m_s         = m_r;
    n_s         = n_r;
    buf_s       = buf_r;
    case (state_r)
      StIdle: begin
        if (start_i) begin
          m_tiles_s   = M_size_i / RowParS;
          n_tiles_s   = N_size_i / ColParS;
          row_base_s  = SZero;
          col_base_s  = SZero;
          mt_s        = AZero;
          nt_s        = AZero;
          tile_addr_s = AZero;
          m_s         = MZero;
          n_s         = NZero;
          if ((m_tiles_s == SZero) || (n_tiles_s == SZero)) begin
            state_s = StDone;
          end else begin
            state_s = StFetch;
          end
        end else begin
          state_s = StIdle;
        end
      end
      StFetch: begin
        state_s = StWait;
      end
      StWait: begin
        buf_s   = sram_c_rdata_i;
        m_s     = MZero;
        n_s     = NZero;
        state_s = StEmit;
      end
      StEmit: begin
        if (hs_s) begin
          if (elem_last_s) begin
            if (tile_final_s) begin
              state_s = StDone;
            end else begin
              state_s     = StFetch;
              tile_addr_s = tile_addr_r + AddrOne;
              if (nt_last_s) begin
                nt_s       = AZero;
                col_base_s = SZero;
                mt_s       = mt_r + AddrOne;
                row_base_s = row_base_r + RowParS;
              end else begin
                nt_s       = nt_r + AddrOne;
                col_base_s = col_base_r + ColParS;
              end
            end
          end else if (n_r == NLast) begin
            n_s = NZero;
            m_s = m_r + MOne;
          end else begin
            n_s = n_r + NOne;
          end
        end else begin
          state_s = StEmit;
        end
      end
      StDone: begin
        state_s = StIdle;
      end
      default: begin
        state_s = StIdle;
      end
    endcase
  end

  assign final_next_s = (mt_s == AddrWidth'(m_tiles_s) - AddrOne) &&
                        (nt_s == AddrWidth'(n_tiles_s) - AddrOne);

  // Output values decoded from the upcoming state so ports come straight from flops.
  always_comb begin
    re_s    = (state_s == StFetch);
    valid_s = (state_s == StEmit);
    busy_s  = (state_s != StIdle);
    done_s  = (state_s == StDone);
    addr_s  = addr_r;
    data_s  = data_r;
    row_s   = row_r;
    col_s   = col_r;
    last_s  = 1'b0;
    if (re_s) begin
      addr_s = tile_addr_s;
    end else begin
      addr_s = addr_r;
    end
    if (valid_s) begin
      data_s = tile_elem(buf_s, m_s, n_s);
      row_s  = row_base_s + SizeAddrWidth'(m_s);
      col_s  = col_base_s + SizeAddrWidth'(n_s);
      last_s = final_next_s && (m_s == MLast) && (n_s == NLast);
    end else begin
      last_s = 1'b0;
    end
  end

  // State, counter, buffer and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= StIdle;
      m_tiles_r   <= SZero;
      n_tiles_r   <= SZero;
      row_base_r  <= SZero;
      col_base_r  <= SZero;
      mt_r        <= AZero;
      nt_r        <= AZero;
      tile_addr_r <= AZero;
      m_r         <= MZero;
      n_r         <= NZero;
      buf_r       <= {TileWidth{1'b0}};
      addr_r      <= AZero;
      re_r        <= 1'b0;
      data_r      <= {OutDataWidth{1'b0}};
      row_r       <= SZero;
      col_r       <= SZero;
      last_r      <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      m_tiles_r   <= m_tiles_s;
      n_tiles_r   <= n_tiles_s;
      row_base_r  <= row_base_s;
      col_base_r  <= col_base_s;
      mt_r        <= mt_s;
      nt_r        <= nt_s;
      tile_addr_r <= tile_addr_s;
      m_r         <= m_s;
      n_r         <= n_s;
      buf_r       <= buf_s;
      addr_r      <= addr_s;
      re_r        <= re_s;
      data_r      <= data_s;
      row_r       <= row_s;
      col_r       <= col_s;
      last_r      <= last_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign sram_c_addr_o = addr_r;
  assign sram_c_re_o   = re_r;
  assign out_data_o    = data_r;
  assign out_row_o     = row_r;
  assign out_col_o     = col_r;
  assign out_last_o    = last_r;
  assign out_valid_o   = valid_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;

endmodule

// File: tb/tb_gemm_c_drain.sv
// Randomized bench for gemm_c_drain: element table + SRAM model, expected stream
// built from nested tile/element loops.
module tb_gemm_c_drain;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 8;
  localparam int RP = 4;
  localparam int CP = 16;
  localparam int EL = RP * CP;
  localparam int TW = EL * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [SW-1:0] m_size, n_size;
  logic [AW-1:0] sram_addr;
  logic          sram_re;
  logic [TW-1:0] sram_rdata;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_row, out_col;
  logic          out_last, out_valid, out_ready, busy, done;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] elem_mem [64][RP][CP];

  always #5 clk = ~clk;

  gemm_c_drain dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start_i),
    .M_size_i       (m_size),
    .N_size_i       (n_size),
    .sram_c_addr_o  (sram_addr),
    .sram_c_re_o    (sram_re),
    .sram_c_rdata_i (sram_rdata),
    .out_data_o     (out_data),
    .out_row_o      (out_row),
    .out_col_o      (out_col),
    .out_last_o     (out_last),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .busy_o         (busy),
    .done_o         (done)
  );

  function automatic logic [TW-1:0] pack_word(input int a);
    logic [TW-1:0] w;
    w = '0;
    for (int m = 0; m < RP; m++)
      for (int n = 0; n < CP; n++)
        w[(EL - 1 - (m * CP + n)) * DW +: DW] = elem_mem[a][m][n];
    return w;
  endfunction

  // SRAM C: one-cycle read latency.
  always @(posedge clk) begin
    if (sram_re) sram_rdata <= pack_word(int'(sram_addr[5:0]));
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int m_sz, input int n_sz, input bit rnd_ready,
                     input int restart_cyc, input int abort_at);
    logic [63:0] exp_q[$];
    logic [63:0] held, cur, e;
    int mtn, ntn, tiles, exp_addr, hs;
    bit stalled, done_seen;
    mtn = m_sz / RP;
    ntn = n_sz / CP;
    tiles = mtn * ntn;
    exp_addr = 0;
    hs = 0;
    stalled = 1'b0;
    done_seen = 1'b0;
    held = '0;
    for (int mt = 0; mt < mtn; mt++)
      for (int nt = 0; nt < ntn; nt++)
        for (int m = 0; m < RP; m++)
          for (int n = 0; n < CP; n++) begin
            e = '0;
            e[48]    = (mt == mtn - 1) && (nt == ntn - 1) && (m == RP - 1) && (n == CP - 1);
            e[47:40] = 8'(mt * RP + m);
            e[39:32] = 8'(nt * CP + n);
            e[31:0]  = elem_mem[mt * ntn + nt][m][n];
            exp_q.push_back(e);
          end

    @(negedge clk);
    m_size  = 8'(m_sz);
    n_size  = 8'(n_sz);
    start_i = 1'b1;
    @(negedge clk);
    // M/N changed mid-run must be ignored.
    m_size = 8'($urandom_range(0, 255));
    n_size = 8'($urandom_range(0, 255));
    check_eq("busy_start", {63'd0, busy}, 64'd1);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      start_i = (cyc == restart_cyc);
      if (sram_re) begin
        if (exp_addr >= tiles) check_eq("extra_read", 64'd1, 64'd0);
        else check_eq("rd_addr", {48'd0, sram_addr}, 64'(exp_addr));
        exp_addr++;
      end
      cur = {14'd0, out_valid, out_last, out_row, out_col, out_data};
      if (stalled) check_eq("stall_hold", cur, held);
      if (done) begin
        if (!rnd_ready) check_eq("done_cyc", 64'(cyc), 64'(tiles * (EL + 2) + 1));
        check_eq("elems_left", 64'(exp_q.size()), 64'd0);
        check_eq("read_count", 64'(exp_addr), 64'(tiles));
        done_seen = 1'b1;
        break;
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) check_eq("extra_elem", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check_eq("elem", cur[48:0], e);
          end
          hs++;
        end else begin
          stalled = 1'b1;
          held = cur;
        end
      end
      if (abort_at >= 0 && hs == abort_at) break;
      @(negedge clk);
    end
    start_i = 1'b0;
    if (abort_at >= 0) begin
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_eq("rst_outs", {sram_addr, sram_re, out_data, out_last, out_valid, busy, done},
                  64'd0);
      @(negedge clk);
      check_eq("rst_hold", {out_row, out_col, 48'd0}, 64'd0);
      rst_n = 1'b1;
    end else if (!done_seen) begin
      check_eq("done_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      check_eq("idle_after", {62'd0, busy, done}, 64'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start_i   = 1'b0;
    m_size    = 8'd0;
    n_size    = 8'd0;
    out_ready = 1'b1;
    for (int a = 0; a < 64; a++)
      for (int m = 0; m < RP; m++)
        for (int n = 0; n < CP; n++)
          elem_mem[a][m][n] = $urandom;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {sram_addr, sram_re, out_data, out_last, out_valid, busy, done}, 64'd0);
    check_eq("reset_coord", {48'd0, out_row, out_col}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4, 16, 1'b0, -1, -1);
    run(8, 32, 1'b0, -1, -1);
    run(8, 16, 1'b1, -1, -1);
    run(0, 16, 1'b0, -1, -1);
    run(8, 8, 1'b0, -1, -1);
    run(4, 16, 1'b0, 10, -1);
    run(12, 48, 1'b1, 40, -1);
    run(4, 16, 1'b0, -1, 20);
    run(4, 16, 1'b0, -1, -1);
    run(7, 33, 1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
